// File: rtl/muldiv_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// MULDIV_DIV_EN enables the divider; without it DIV/DIVU starts pulse illegal_o.
package types;
  parameter int WIDTH = 32;
endpackage

module muldiv_unit #(
  parameter int WIDTH = types::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc, acc_nx, mul_nx, prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_q, sgn, accept, div_rej;

`ifdef MULDIV_DIV_EN
  logic               is_div, neg_r, bz;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   diff, q, r;
  logic               ge;
  logic [2*WIDTH-1:0] div_nx;
  assign div_rej = 1'b0;
`else
  assign div_rej = op_i[1];
`endif

  assign sgn    = ~op_i[0];
  assign a_mag  = (sgn && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign b_mag  = (sgn && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
  assign accept = (state == IDLE) && start_i && !div_rej;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc holds {partial/remainder, multiplier/quotient}
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    mul_nx = acc[0] ? {sum, acc[WIDTH-1:1]}
                    : {1'b0, acc[2*WIDTH-1:1]};
    prod   = neg_q ? (~acc + 1'b1) : acc;
    acc_nx = mul_nx;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    shl    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge     = shl >= {1'b0, opb};
    diff   = shl[WIDTH-1:0] - opb;
    div_nx = ge ? {diff, acc[WIDTH-2:0], 1'b1}
                : {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    q      = acc[WIDTH-1:0];
    r      = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      acc_nx = div_nx;
      res_hi = neg_r ? (~r + 1'b1) : r;
      res_lo = bz ? '1 : (neg_q ? (~q + 1'b1) : q);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      busy_o    <= state_nx != IDLE;
      done_o    <= state == FIX;
      illegal_o <= ((state != IDLE) && (hi_we_i || lo_we_i))
                || ((state == IDLE) && start_i && div_rej);
      if (state == IDLE) begin
        if (hi_we_i) hi_o <= wdata_i;
        if (lo_we_i) lo_o <= wdata_i;
      end
      if (state == FIX) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cnt   <= '0;
      acc   <= {{WIDTH{1'b0}}, a_mag};
      opb   <= b_mag;
      neg_q <= sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef MULDIV_DIV_EN
      is_div <= op_i[1];
      neg_r  <= sgn && a_i[WIDTH-1];
      bz     <= b_i == '0;
`endif
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
// Divide scenarios follow the MULDIV_DIV_EN build setting.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, illegal;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .hi_we_i(hi_we), .lo_we_i(lo_we),
    .wdata_i(wdata), .busy_o(busy), .done_o(done),
    .illegal_o(illegal), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int ill);
    lat = 0;
    ill = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (illegal === 1'b1) ill++;
    end
    if (lat >= 100) begin
      checks++; errors++;
      $display("FAIL wait_done timeout got done=%b want 1", done);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int lat, ill;
    start_op(o, x, y);
    wait_done(lat, ill);
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL %s_lat got %0d want 33", nm, lat);
    end
    checks++;
    if (hi !== eh) begin
      errors++; $display("FAIL %s_hi got %h want %h", nm, hi, eh);
    end
    checks++;
    if (lo !== el) begin
      errors++; $display("FAIL %s_lo got %h want %h", nm, lo, el);
    end
  endtask

  task automatic mt_write(input logic h, input logic [31:0] d);
    hi_we = h; lo_we = !h; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b want 000", busy, done, illegal);
    end
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_mt();
    mt_write(1'b1, 32'h11111111);
    checks++;
    if (hi !== 32'h11111111 || done !== 1'b0) begin
      errors++; $display("FAIL mthi got %h done=%b want 11111111 0", hi, done);
    end
    mt_write(1'b0, 32'h22222222);
    checks++;
    if (lo !== 32'h22222222 || hi !== 32'h11111111) begin
      errors++; $display("FAIL mtlo got %h/%h want 11111111/22222222", hi, lo);
    end
  endtask

  task automatic test_mult();
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_pos", 2'b00, 32'd100000, 32'd300000, 32'h00000006, 32'hFC23AC00);
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu_big", 2'b11, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999);
  endtask
`else
  task automatic test_div_disabled();
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (illegal !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL nodiv_flag got ill=%b busy=%b want 1 0", illegal, busy);
    end
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nodiv_after got ill=%b done=%b busy=%b want 000",
                         illegal, done, busy);
    end
    checks++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
      errors++; $display("FAIL nodiv_hilo got %h/%h want 11111111/22222222", hi, lo);
    end
  endtask
`endif

  task automatic test_busy_write();
    int lat, ill;
    mt_write(1'b1, 32'h0BADF00D);
    start_op(2'b00, 32'd5, 32'hFFFFFFFC);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL bw_busy got %b want 1", busy);
    end
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (illegal !== 1'b1) begin
      errors++; $display("FAIL bw_illegal got %b want 1", illegal);
    end
    checks++;
    if (hi !== 32'h0BADF00D) begin
      errors++; $display("FAIL bw_hi_hold got %h want 0badf00d", hi);
    end
    wait_done(lat, ill);
    checks++;
    if (lat !== 28 || ill !== 0) begin
      errors++; $display("FAIL bw_lat got %0d/%0d want 28/0", lat, ill);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEC) begin
      errors++; $display("FAIL bw_result got %h/%h want ffffffff/ffffffec", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL bw_restart got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    mt_write(1'b1, 32'h00001234);
    mt_write(1'b0, 32'h00005678);
`ifdef MULDIV_DIV_EN
    start_op(2'b10, 32'd100, 32'd7);
`else
    start_op(2'b00, 32'd100, 32'd7);
`endif
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL rstmid got busy=%b %h/%h want 0 0/0", busy, hi, lo);
    end
    nd = 0;
    repeat (40) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd !== 0 || hi !== 32'h0) begin
      errors++; $display("FAIL rstmid_done got %0d pulses hi=%h want 0 0", nd, hi);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ill;
    run_op("b2b_first", 2'b01, 32'd3, 32'd5, 32'h0, 32'd15);
    start_op(2'b01, 32'h00010000, 32'h00010000);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat, ill);
    checks++;
    if (lat !== 33 || hi !== 32'h1 || lo !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d %h/%h want 33 1/0", lat, hi, lo);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mt();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_mult();
    test_busy_write();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multicycle integer multiply/divide unit with architectural HI/LO registers, executing MULT, MULTU, DIV, DIVU and accepting MTHI/MTLO writes. It sits beside the ALU in the execute stage. The pipeline stalls on `busy_o` and reads `hi_o`/`lo_o` for MFHI/MFLO. It is fully parametrised on datapath width (`WIDTH`, default from the `types` package) and is the sequential counterpart to the combinational ALU.

## Interface
- `WIDTH`, default `types::WIDTH` (32): operand and HI/LO width, minimum 4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start_i` in 1: request an operation; sampled only in IDLE.
- `op_i` in 2: `00` MULT, `01` MULTU, `10` DIV, `11` DIVU.
- `a_i` in WIDTH: rs operand (multiplicand / dividend).
- `b_i` in WIDTH: rt operand (multiplier / divisor).
- `hi_we_i` in 1: MTHI write strobe.
- `lo_we_i` in 1: MTLO write strobe.
- `wdata_i` in WIDTH: MTHI/MTLO data.
- `busy_o` out 1: operation in flight.
- `done_o` out 1: one-cycle pulse when HI/LO have been updated by an operation.
- `illegal_o` out 1: one-cycle pulse on a rejected request.
- `hi_o` out WIDTH: HI register.
- `lo_o` out WIDTH: LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC when `start_i` is high. Latch `op_i`, operand magnitudes (signed ops) or raw operands (unsigned ops), and result signs. Clear the step counter.
  - CALC runs exactly WIDTH steps, one per cycle. Multiply is radix-2 shift-add over a 2·WIDTH accumulator. Divide is restoring, with a WIDTH-bit remainder plus a carry bit.
  - CALC → FIX after step WIDTH−1.
  - FIX: apply sign correction and write HI/LO, then → IDLE.
- Multiply results: HI = upper WIDTH bits and LO = lower WIDTH bits of the 2·WIDTH product. MULT is signed; MULTU is unsigned.
- Divide results: LO = quotient (truncated toward zero), HI = remainder. For DIV, the remainder takes the sign of the dividend.
- Divide by zero: runs the full latency, then LO = all ones and HI = `a_i` (as latched).
- DIV of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1), HI = 0. No exception is raised.
- MTHI/MTLO:
  - In IDLE, `hi_we_i`/`lo_we_i` write `wdata_i` on the next edge.
  - While busy, the write is dropped and `illegal_o` pulses.
- `start_i` while busy is ignored. It has no effect and does not pulse `illegal_o`.
- `start_i` together with a write strobe in IDLE: the write takes effect, the start is also accepted, and the operation result later overwrites HI/LO.
- Reset (at any time, including mid-operation):
  - state = IDLE; HI = LO = 0.
  - `busy_o`, `done_o`, `illegal_o` = 0.
  - Any in-flight result is discarded.

## Timing
- A start is accepted on edge E0.
- `busy_o` is high from after E0 through the cycle ending at edge E0+WIDTH+1.
- At edge E0+WIDTH+1, HI/LO are written, `done_o` is high for that one cycle, and `busy_o` falls.
- Total latency is WIDTH+1 cycles (33 for WIDTH=32). It is independent of operand values.
- Back-to-back operations: a new `start_i` can be accepted on the edge after `done_o`, i.e. one idle cycle between operations.
- MTHI/MTLO latency is 1 cycle, with no `done_o`.
- `busy_o` and `done_o` are registered. `illegal_o` is registered, so it pulses the cycle after the rejected strobe.
- `hi_o`/`lo_o` are direct register outputs and are stable while busy.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as above.
- `MULDIV_DIV_EN` undefined: the divider datapath is removed.
  - DIV/DIVU starts are not executed: HI/LO are unchanged, `busy_o` stays low, `done_o` stays low, and `illegal_o` pulses once.
  - Multiply and MTHI/MTLO behaviour is unchanged.

## Test plan
All scenarios use WIDTH=32.
- Reset: assert `rst` for 2 cycles, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
  - After reset: HI = LO = 0, `busy_o` = 0.
  - After 33 cycles: HI=0xFFFFFFFE, LO=0x00000001, and `done_o` is a single pulse.
- MULT a=−3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Boundaries:
  - `start_i` and `hi_we_i` at cycle 5 of a running MULT: no restart, HI unchanged by the write, `illegal_o` pulses once, and the result is correct.
  - `rst` at cycle 10 of a DIV: the unit is IDLE next cycle with HI = LO = 0, and `done_o` never pulses.
  - Build without `MULDIV_DIV_EN`: DIV start → `illegal_o` pulse, HI/LO unchanged, `busy_o` = 0.
